fp_addsub_pipe: RTL and testbench

- Parametrised, 3-stage pipelined floating-point add/subtract core for the FPA pipeline.
- Generalises the exponent-difference and sign-controlled mantissa add/complement path to arbitrary exponent and fraction widths.
- Adds operand swap, alignment shift, normalisation, special-case handling and a valid/ready handshake with full backpressure.
- Sits between the operand-fetch stage and the result writeback stage.

---
 rtl/fp_addsub_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract with valid/ready backpressure.
// Denormals flush to zero, rounding is truncation, infinities/NaNs force a signed infinity.
module fp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    flag_zero,
  output logic                    flag_ovf,
  output logic                    flag_uf
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int MAN_W = FRAC_W + 1;
  localparam int SUM_W = FRAC_W + 2;
  localparam int LZ_W  = $clog2(MAN_W + 1);
  localparam int SE_W  = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [EXP_W-1:0]       EXP_ONES = '1;
  localparam logic [SUM_W-1:0]       SUM_ONE  = SUM_W'(1);
  localparam logic [LZ_W-1:0]        LZ_ONE   = LZ_W'(1);
  localparam logic signed [SE_W-1:0] SE_ONE   = SE_W'(1);
  localparam logic signed [SE_W-1:0] SE_ZERO  = '0;
  localparam logic signed [SE_W-1:0] EXP_MAX  = {{(SE_W-EXP_W){1'b0}}, EXP_ONES};

  typedef struct packed {
    logic [W-1:0] word;
    logic         zero;
    logic         ovf;
    logic         uf;
  } res_t;

  function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] x);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      n = n + LZ_ONE;
      end
    end
    return n;
  endfunction

  // Saturating pack: exponent overflow becomes infinity, non-positive exponent flushes to signed zero.
  function automatic res_t pack_sat(input logic s, input logic signed [SE_W-1:0] e,
                                    input logic [FRAC_W-1:0] f);
    res_t r;
    r = '0;
    if (e >= EXP_MAX) begin
      r.word = {s, EXP_ONES, {FRAC_W{1'b0}}};
      r.ovf  = 1'b1;
    end else if (e <= SE_ZERO) begin
      r.word = {s, {(W-1){1'b0}}};
      r.uf   = 1'b1;
      r.zero = 1'b1;
    end else begin
      r.word = {s, e[EXP_W-1:0], f};
    end
    return r;
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic ld_p0, ld_p1, ld_p2;

  assign ld_p2    = !vld_p2 || out_ready;
  assign ld_p1    = !vld_p1 || ld_p2;
  assign ld_p0    = !vld_p0 || ld_p1;
  assign in_ready = ld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: unpack, flush denormals, order operands by magnitude ----
  logic             sa, sb_eff, a_big, a_inf, b_inf;
  logic [EXP_W-1:0] ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic [MAN_W-1:0] man_a, man_b;

  assign {sa, ea, fa} = a;
  assign eb     = b[W-2:FRAC_W];
  assign fb     = b[FRAC_W-1:0];
  assign sb_eff = b[W-1] ^ op;
  assign man_a  = (ea == '0) ? '0 : {1'b1, fa};
  assign man_b  = (eb == '0) ? '0 : {1'b1, fb};
  assign a_big  = {ea, fa} >= {eb, fb};
  assign a_inf  = (ea == EXP_ONES);
  assign b_inf  = (eb == EXP_ONES);

  logic             sign_l_p0, sign_s_p0, spec_p0, spec_sign_p0;
  logic [EXP_W-1:0] exp_l_p0, shamt_p0;
  logic [MAN_W-1:0] man_l_p0, man_s_p0;
  logic [TAG_W-1:0] tag_p0;

  always_ff @(posedge clk) begin
    if (ld_p0 && in_valid) begin
      spec_p0      <= a_inf || b_inf;
      spec_sign_p0 <= a_inf ? sa : sb_eff;
      tag_p0       <= in_tag;
      if (a_big) begin
        sign_l_p0 <= sa;
        sign_s_p0 <= sb_eff;
        exp_l_p0  <= ea;
        shamt_p0  <= ea - eb;
        man_l_p0  <= man_a;
        man_s_p0  <= man_b;
      end else begin
        sign_l_p0 <= sb_eff;
        sign_s_p0 <= sa;
        exp_l_p0  <= eb;
        shamt_p0  <= eb - ea;
        man_l_p0  <= man_b;
        man_s_p0  <= man_a;
      end
    end
  end

  // ---- stage 2: align smaller mantissa (truncating) and add or subtract ----
  logic [SUM_W-1:0] man_l_ext, man_s_al, sum_s2;

  assign man_l_ext = {1'b0, man_l_p0};
  assign man_s_al  = (int'(shamt_p0) >= SUM_W) ? '0 : ({1'b0, man_s_p0} >> shamt_p0);
  assign sum_s2    = (sign_l_p0 == sign_s_p0) ? (man_l_ext + man_s_al)
                                              : (man_l_ext + (~man_s_al + SUM_ONE));

  logic             sign_p1, spec_p1, spec_sign_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [SUM_W-1:0] sum_p1;
  logic [TAG_W-1:0] tag_p1;

  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) begin
      sum_p1       <= sum_s2;
      sign_p1      <= sign_l_p0;
      exp_p1       <= exp_l_p0;
      spec_p1      <= spec_p0;
      spec_sign_p1 <= spec_sign_p0;
      tag_p1       <= tag_p0;
    end
  end

  // ---- stage 3: normalise, saturate and pack ----
  logic [LZ_W-1:0]        lz;
  logic signed [SE_W-1:0] exp_ext, lz_ext, exp_n;
  logic [FRAC_W-1:0]      frac_n;
  res_t                   res_s3;

  always_comb begin
    res_s3  = '0;
    lz      = lzc(sum_p1[MAN_W-1:0]);
    exp_ext = signed'({{(SE_W-EXP_W){1'b0}}, exp_p1});
    lz_ext  = signed'({{(SE_W-LZ_W){1'b0}}, lz});
    if (sum_p1[SUM_W-1]) begin
      exp_n  = exp_ext + SE_ONE;
      frac_n = sum_p1[FRAC_W:1];
    end else begin
      exp_n  = exp_ext - lz_ext;
      frac_n = sum_p1[FRAC_W-1:0] << lz;
    end
    if (spec_p1) begin
      res_s3.word = {spec_sign_p1, EXP_ONES, {FRAC_W{1'b0}}};
      res_s3.ovf  = 1'b1;
    end else if (sum_p1 == '0) begin
      res_s3.zero = 1'b1;
    end else begin
      res_s3 = pack_sat(sign_p1, exp_n, frac_n);
    end
  end

  res_t             res_p2;
  logic [TAG_W-1:0] tag_p2;

  always_ff @(posedge clk) begin
    if (ld_p2 && vld_p1) begin
      res_p2 <= res_s3;
      tag_p2 <= tag_p1;
    end
  end

  // Data registers carry no reset; outputs read as zero whenever no result is held.
  assign out_valid = vld_p2;
  assign result    = vld_p2 ? res_p2.word : '0;
  assign out_tag   = vld_p2 ? tag_p2      : '0;
  assign flag_zero = vld_p2 && res_p2.zero;
  assign flag_ovf  = vld_p2 && res_p2.ovf;
  assign flag_uf   = vld_p2 && res_p2.uf;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (binary32 configuration): hand-computed vectors,
// latency, random stalls, backpressure and mid-flight reset.
module tb_fp_addsub_pipe;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int TAG_W  = 4;
  localparam int NVEC   = 13;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        u;
  } vec_t;

  typedef struct packed {
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic             z;
    logic             o;
    logic             u;
  } exp_t;

  logic             clk, rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0]      a, b, result;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             flag_zero, flag_ovf, flag_uf;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   bp_idx [5] = '{0, 2, 5, 6, 8};
  int   n_vec  = 0;
  int   n_fail = 0;

  fp_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flag_zero(flag_zero), .flag_ovf(flag_ovf),
    .flag_uf(flag_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic load_vectors();
    //               a             b             op    result        z     o     u
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'hBF800000, 32'h40400000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b1, 1'b0};
  endtask

  task automatic drive(input int idx, input logic [TAG_W-1:0] tag);
    int   waited;
    logic acc;
    waited = 0;
    acc    = 1'b0;
    in_valid = 1'b1;
    a = vecs[idx].a; b = vecs[idx].b; op = vecs[idx].op; in_tag = tag;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    if (acc) begin
      exp_q.push_back('{vecs[idx].r, tag, vecs[idx].z, vecs[idx].o, vecs[idx].u});
    end else begin
      n_vec++; n_fail++;
      $display("FAIL drive tag %0d: in_ready got 0 for 100 cycles, want 1", tag);
    end
  endtask

  task automatic collect(input int n, input string name, output int first_cyc);
    int   got, cyc;
    exp_t e;
    got = 0; cyc = 0; first_cyc = 0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        if (got == 0) first_cyc = cyc;
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected output: got result %h tag %0d, want none", name, result, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.r) begin
            n_fail++;
            $display("FAIL %s result tag %0d: got %h want %h", name, e.tag, result, e.r);
          end
          n_vec++;
          if (out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL %s out_tag: got %0d want %0d", name, out_tag, e.tag);
          end
          n_vec++;
          if ({flag_zero, flag_ovf, flag_uf} !== {e.z, e.o, e.u}) begin
            n_fail++;
            $display("FAIL %s flags tag %0d: got zof=%b%b%b want %b%b%b", name, e.tag,
                     flag_zero, flag_ovf, flag_uf, e.z, e.o, e.u);
          end
        end
      end
    end
    n_vec++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s count: got %0d results want %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = vecs[0].a; b = vecs[0].b; op = vecs[0].op; in_tag = 4'h7;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_vec++;
    if (result !== 32'h0 || out_tag !== '0) begin
      n_fail++; $display("FAIL reset outputs: got result %h tag %0d want 0 0", result, out_tag);
    end
    n_vec++;
    if ({flag_zero, flag_ovf, flag_uf} !== 3'b000) begin
      n_fail++; $display("FAIL reset flags: got %b%b%b want 000", flag_zero, flag_ovf, flag_uf);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid) seen++; end
    n_vec++;
    if (seen != 0) begin n_fail++; $display("FAIL reset priority: got %0d outputs want 0", seen); end
  endtask

  task automatic test_basic_latency();
    int first;
    @(posedge clk); #1;
    drive(0, 4'd5);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency edge1 out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency edge2 out_valid: got %b want 0", out_valid); end
    collect(1, "latency", first);
    n_vec++;
    if (first != 1) begin n_fail++; $display("FAIL latency edge3 arrival: got cycle %0d want 1", first); end
  endtask

  task automatic test_vectors();
    int first;
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin for (int i = 0; i < NVEC; i++) drive(i, 4'(i)); end
      collect(NVEC, "vectors", first);
    join
  endtask

  task automatic test_back_to_back_stall();
    int   first;
    logic done;
    done = 1'b0;
    @(posedge clk); #1;
    fork
      begin for (int i = 0; i < NVEC; i++) drive(NVEC - 1 - i, 4'(i + 3)); end
      begin collect(NVEC, "stall", first); done = 1'b1; end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
  endtask

  task automatic test_backpressure();
    int first;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin for (int i = 0; i < 5; i++) drive(bp_idx[i], 4'(i + 1)); end
      begin
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp in_ready before 3rd accept: got %b want 1", in_ready); end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready after 3 accepts: got %b want 0", in_ready); end
        n_vec++;
        if (out_valid !== 1'b1 || result !== vecs[0].r || out_tag !== 4'd1) begin
          n_fail++;
          $display("FAIL bp head: got v=%b %h tag %0d want 1 %h 1", out_valid, result, out_tag, vecs[0].r);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || result !== vecs[0].r || out_tag !== 4'd1) begin
          n_fail++;
          $display("FAIL bp hold: got v=%b %h tag %0d want 1 %h 1", out_valid, result, out_tag, vecs[0].r);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      collect(5, "backpressure", first);
    join
  endtask

  task automatic test_reset_in_flight();
    int seen;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(3, 4'hA);
    drive(7, 4'hB);
    rst = 1'b1; in_valid = 1'b1;
    a = vecs[0].a; b = vecs[0].b; op = vecs[0].op; in_tag = 4'hC;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush in_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (10) begin @(negedge clk); if (out_valid) seen++; end
    n_vec++;
    if (seen != 0) begin n_fail++; $display("FAIL flush discarded ops: got %0d outputs want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    load_vectors();
    test_reset();
    test_basic_latency();
    test_vectors();
    test_back_to_back_stall();
    test_backpressure();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
